// File: rtl/timeout_pkg.sv
`default_nettype none
// ============================================================================
// Module   : timeout_pkg
// Purpose  : Shared state encoding and width helpers for the timeout
//            controller and its tick prescaler.
// Revision : 1.0 - initial release
// ============================================================================
package timeout_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_RUN     = 3'd2,
    ST_EXPIRED = 3'd3,
    ST_STOPPED = 3'd4
  } state_e;

  // Ceiling log2; clog2(1) is 0.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      res = res + 1;
    end
    return res;
  endfunction

  // Width of a down-counter holding 0..value-1, never narrower than 1 bit.
  function automatic int presc_width(input int value);
    return (clog2(value) < 1) ? 1 : clog2(value);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : tick_prescaler
// Purpose  : Reloading down-counter that emits one tick every PRESCALE
//            enabled cycles. load restarts the period from the top.
// Revision : 1.0 - initial release
// ============================================================================
module tick_prescaler
  import timeout_pkg::*;
#(
  parameter int PRESCALE = 50
) (
  input  logic clk,
  input  logic rst,     // asynchronous, active-low
  input  logic load,
  input  logic en,
  output logic tick
);

  localparam int            PW     = presc_width(PRESCALE);
  localparam logic [PW-1:0] RELOAD = PW'(PRESCALE - 1);

  logic [PW-1:0] count_q;
  logic [PW-1:0] count_d;

  assign tick = en && (count_q == '0);

  // Next count: explicit reload wins, otherwise count down and wrap to RELOAD.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = RELOAD;
    end else if (en) begin
      count_d = (count_q == '0) ? RELOAD : (count_q - PW'(1));
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= RELOAD;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/timeout_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : timeout_ctrl
// Purpose  : Arms an external up-counter through a prescaler and reports
//            either a timeout or the elapsed tick count when the awaited
//            response arrives.
// Revision : 1.0 - initial release
// ============================================================================
module timeout_ctrl
  import timeout_pkg::*;
#(
  parameter int PRESCALE = 50,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,      // asynchronous, active-low
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] limit,
  input  logic [CNT_W-1:0] cnt_q,
  output logic             cnt_clr,
  output logic             cnt_up,
  output logic             busy,
  output logic             timeout,
  output logic             done,
  output logic [CNT_W-1:0] elapsed
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   limit_q, limit_d;
  logic [CNT_W-1:0]   elapsed_q, elapsed_d;
  logic               clr_q, clr_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;
  logic               done_q, done_d;
  logic               w_tick;
  logic               w_at_limit;

  // Counter has reached the sampled limit; stops counting and triggers expiry.
  assign w_at_limit = (cnt_q >= limit_q);

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_presc (
    .clk  (clk),
    .rst  (rst),
    .load (state_q == ST_CLEAR),
    .en   (state_q == ST_RUN),
    .tick (w_tick)
  );

  // Gating on the limit keeps the counter from ever passing limit_q.
  assign cnt_up  = w_tick && !w_at_limit;
  assign cnt_clr = clr_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;
  assign done    = done_q;
  assign elapsed = elapsed_q;

  // Next-state, limit sampling and capture; clear/busy follow the next state.
  always_comb begin
    state_d   = state_q;
    limit_d   = limit_q;
    elapsed_d = elapsed_q;
    timeout_d = timeout_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CLEAR;
          limit_d = limit;
        end
      end
      ST_CLEAR: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (start) begin
          state_d = ST_CLEAR;
          limit_d = limit;
        end else if (stop) begin
          state_d   = ST_STOPPED;
          done_d    = 1'b1;
          elapsed_d = cnt_q;
        end else if (w_at_limit) begin
          state_d   = ST_EXPIRED;
          timeout_d = 1'b1;
          elapsed_d = cnt_q;
        end
      end
      ST_EXPIRED, ST_STOPPED: begin
        if (start) begin
          state_d = ST_CLEAR;
          limit_d = limit;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (state_d == ST_CLEAR) begin
      timeout_d = 1'b0;
    end
    busy_d = (state_d == ST_CLEAR) || (state_d == ST_RUN);
    clr_d  = (state_d == ST_IDLE)  || (state_d == ST_CLEAR);
  end

  // State and registered outputs; clear held high in reset keeps counter at 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      limit_q   <= '0;
      elapsed_q <= '0;
      clr_q     <= 1'b1;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      limit_q   <= limit_d;
      elapsed_q <= elapsed_d;
      clr_q     <= clr_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/timeout_ctrl.md
Name: timeout_ctrl

Overview:
- Timeout/elapsed-time controller used by the bootloader while it waits for slow peripheral responses, such as an SD card reply or a flash busy flag.
- Sits directly upstream of the team's 32-bit up-counter (ports clk/rst/up/q):
  - drives that counter's synchronous active-high clear and its count-enable strobe;
  - reads back the counter value q to detect expiry and to capture elapsed ticks.
- Adds a prescaler, so one count corresponds to PRESCALE clock cycles.

Parameters:
- PRESCALE, 50: clk cycles per counter tick; legal range >= 1.
- CNT_W, 32: counter/limit width; must match the up-counter width.

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request: arm the timer. Samples limit; legal in any state.
- stop  in  1  one-cycle event: awaited response arrived. Ignored unless state is RUN.
- limit  in  CNT_W  timeout in ticks. Sampled into limit_r only on an accepted start.
- cnt_q  in  CNT_W  current value from the up-counter's q.
- cnt_clr  out  1  drives the up-counter's synchronous clear; registered.
- cnt_up  out  1  one-cycle count-enable tick to the up-counter.
- busy  out  1  high in CLEAR and RUN.
- timeout  out  1  sticky; set on expiry, cleared by the next start.
- done  out  1  one-cycle pulse when stop is accepted.
- elapsed  out  CNT_W  cnt_q captured on stop or on expiry.

Behaviour:
- States: IDLE, CLEAR, RUN, EXPIRED, STOPPED. All outputs are registered except cnt_up, which is decoded from the state and prescaler registers.
- Reset (rst=0, asynchronous): state=IDLE, cnt_clr=1, cnt_up=0, busy=0, timeout=0, done=0, elapsed=0, prescaler=PRESCALE-1, limit_r=0. Holding cnt_clr=1 during reset keeps the synchronously-reset counter at 0.
- IDLE: cnt_clr=1. On start: go to CLEAR and latch limit_r=limit.
- CLEAR (exactly 1 cycle):
  - cnt_clr=1, busy=1, timeout cleared to 0, prescaler loaded with PRESCALE-1;
  - next state is RUN.
- RUN:
  - cnt_clr=0.
  - Prescaler decrements each cycle. When it is 0, cnt_up=1 and it reloads PRESCALE-1.
  - cnt_up is gated to 0 whenever cnt_q >= limit_r, so the counter never passes limit_r, including at PRESCALE=1.
- Exits from RUN, in priority order:
  1. start: go to CLEAR (restart, new limit sampled).
  2. stop: go to STOPPED; done=1 for 1 cycle; elapsed=cnt_q; busy=0.
  3. cnt_q >= limit_r (unsigned compare): go to EXPIRED; timeout=1; elapsed=cnt_q; busy=0.
- Simultaneous stop and expiry condition in the same cycle: stop wins, so done=1 and timeout stays 0.
- EXPIRED and STOPPED:
  - hold all outputs; cnt_clr=0, so the counter holds its value;
  - stop is ignored; start goes to CLEAR.
- start and stop in the same IDLE cycle: start is accepted, stop is ignored.
- Timing, with the start-sampling edge as edge 0:
  - CLEAR at edge 1, RUN at edge 2;
  - first cnt_up in the cycle after edge 2+PRESCALE-1;
  - timeout rises at edge PRESCALE*limit+3;
  - limit=0 gives timeout at edge 3 with zero cnt_up pulses.
- Width rules: limit_r and elapsed are CNT_W unsigned. The prescaler width is clog2(PRESCALE), minimum 1 bit. No wrap-around is possible, because counting stops at limit_r.
- Reset asserted mid-RUN: immediate return to reset values. The counter is cleared on the next clk edge via cnt_clr.

Decomposition:
- Shared package timeout_pkg:
  - state enum: IDLE=0, CLEAR=1, RUN=2, EXPIRED=3, STOPPED=4, 3-bit encoding;
  - helper function clog2.
- One sub-module is natural: tick_prescaler (clk, rst, load, en, tick). It owns the reload counter.
- FSM, compare, and capture logic stay in timeout_ctrl.
- Bench instantiates timeout_ctrl together with the real up-counter.

Test Plan:
1. Basic expiry: PRESCALE=4, limit=3, start at edge 0, no stop -> cnt_up pulses after edges 5, 9 and 13; timeout=1 and busy=0 at edge 15; elapsed=3; counter holds 3.
2. Early stop: PRESCALE=4, limit=100, stop after edge 10 -> done is a single pulse at edge 11; elapsed=2; timeout stays 0; state STOPPED.
3. limit=0: start -> no cnt_up; timeout=1 at edge 3; elapsed=0.
4. Stop coincident with expiry, PRESCALE=1, limit=5:
   - stop raised in the cycle where cnt_q first equals 5 -> done=1, timeout=0, elapsed=5;
   - counter never reads 6.
5. Restart: start mid-RUN, then start again in EXPIRED with limit=2 -> CLEAR for one cycle; cnt_clr=1; timeout drops to 0; new expiry yields elapsed=2.
6. Async reset mid-RUN at an arbitrary phase -> outputs return to reset values without a clock edge; cnt_clr=1; counter reads 0 after the next edge; stop in IDLE produces no done.
